key_conditioner: RTL and testbench

Pushbutton input conditioner for the DE-board KEY inputs. It synchronises one active-low KEY into `CLOCK_50` and debounces it. It then emits clean single-cycle press, release and auto-repeat pulses plus a 4-bit step count. It sits on the input side of the lab top level, between the raw KEY pin and the counter and display logic, so that no raw KEY is ever used as a clock.

---
 rtl/key_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_key_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions one raw active-low pushbutton for use in the CLOCK_50 domain.
//   The KEY is passed through a two-flop synchroniser and debounced by a small
//   FSM. The FSM produces registered single-cycle press, release and
//   auto-repeat pulses, a combined step pulse and a 4-bit wrapping step count.
//
// Parameters
//   DEBOUNCE_CYCLES  stable samples needed to accept a level change (>= 1)
//   REPEAT_DELAY     held cycles after the press pulse before the first repeat
//   REPEAT_RATE      cycles between successive repeat pulses
//
// Ports
//   CLOCK_50       in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   KEY_n          in   raw pushbutton, 0 = pressed, asynchronous
//   repeat_en      in   1 enables auto-repeat while held
//   key_level      out  debounced key state, 1 = pressed
//   press_pulse    out  one cycle on an accepted press
//   release_pulse  out  one cycle on an accepted release
//   repeat_pulse   out  one cycle per auto-repeat
//   step           out  press_pulse | repeat_pulse
//   step_count     out  counts steps modulo 16
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       KEY_n,
  input  logic       repeat_en,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       step,
  output logic [3:0] step_count
);

  // One shared counter covers the longest of the three intervals.
  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_WAIT
  } state_t;

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_level;
  logic             r_press;
  logic             r_release;
  logic             r_repeat;
  logic             r_step;
  logic [3:0]       r_step_count;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press;
  logic             w_release;
  logic             w_repeat;
  logic             w_step;
  logic             w_key_level;

  // Synchroniser: both flops idle at 1 (released) so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= KEY_n;
      r_s2 <= r_s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_key_level  <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_repeat     <= 1'b0;
      r_step       <= 1'b0;
      r_step_count <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_key_level  <= w_key_level;
      r_press      <= w_press;
      r_release    <= w_release;
      r_repeat     <= w_repeat;
      r_step       <= w_step;
      r_step_count <= r_step_count + {3'd0, w_step};
    end
  end

  // Next-state logic. Release detection is tested first in HELD and REPEAT so
  // a key let go on the same cycle a repeat interval expires emits no repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_repeat    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!r_s2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (r_s2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (r_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (repeat_en && (r_cnt == RD_LAST)) begin
          w_state_nxt = ST_REPEAT;
          w_cnt_nxt   = '0;
          w_repeat    = 1'b1;
        end else if (repeat_en) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          // Repeat disabled: the delay starts over once it is re-enabled.
          w_cnt_nxt = '0;
        end
      end

      ST_REPEAT: begin
        if (r_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (!repeat_en) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RR_LAST) begin
          w_cnt_nxt = '0;
          w_repeat  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_RELEASE_WAIT: begin
        if (!r_s2) begin
          // Release bounce: back to held with the repeat delay restarted.
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level and step are decoded from the next state so they register in step
  // with the pulses that accompany the transition.
  always_comb begin
    w_key_level = (w_state_nxt == ST_HELD) ||
                  (w_state_nxt == ST_REPEAT) ||
                  (w_state_nxt == ST_RELEASE_WAIT);
    w_step      = w_press | w_repeat;
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;
  assign step          = r_step;
  assign step_count    = r_step_count;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  localparam int K_PRESS = 0;
  localparam int K_REP   = 1;
  localparam int K_REL   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       KEY_n    = 1'b1;
  logic       repeat_en = 1'b0;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;
  logic       step;
  logic [3:0] step_count;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .KEY_n        (KEY_n),
    .repeat_en    (repeat_en),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .step         (step),
    .step_count   (step_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // cyc = number of rising edges seen so far; read on falling edges.
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  exp_cnt = 0;
  int  p;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({key_level, press_pulse, release_pulse, repeat_pulse, step, step_count}), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    q.push_back(e);
  endtask

  // Called on a falling edge: the next rising edge is edge 0, the pulse is
  // visible on the falling edge after edge DC+2.
  task automatic key_down(output int pp);
    KEY_n = 1'b0;
    pp = cyc + 1 + DC + 2;
    expect_ev(K_PRESS, pp);
    exp_cnt = (exp_cnt + 1) % 16;
  endtask

  task automatic key_up();
    KEY_n = 1'b1;
    expect_ev(K_REL, cyc + 1 + DC + 2);
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue.
  task automatic match(input int kind, input string name);
    ev_t e;
    int  want_lvl;
    want_lvl = (kind == K_REL) ? 0 : 1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: pulse at cycle %0d, none expected", name, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != cyc || int'(key_level) != want_lvl) begin
        errors++;
        $display("FAIL %s: got kind %0d cycle %0d level %0d, expected kind %0d cycle %0d level %0d",
                 name, kind, cyc, key_level, e.kind, e.at, want_lvl);
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (press_pulse)   match(K_PRESS, "press");
    if (repeat_pulse)  match(K_REP, "repeat");
    if (release_pulse) match(K_REL, "release");
    checks++;
    if (step !== (press_pulse | repeat_pulse)) begin
      errors++;
      $display("FAIL step: got %0b, expected %0b (cycle %0d)", step, press_pulse | repeat_pulse, cyc);
    end
  end

  initial begin
    // Reset held, then idle with the key released.
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_zero("in_reset");
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_zero("idle");
    end

    // Clean press and release, no repeat.
    key_down(p);
    tick(30);
    chk("held_level", int'(key_level), 1);
    key_up();
    tick(DC + 4);
    chk("release_level", int'(key_level), 0);
    chk("count_after_press", int'(step_count), exp_cnt);

    // Bounce rejection: neither low burst lasts long enough.
    KEY_n = 1'b0; tick(3);
    KEY_n = 1'b1; tick(2);
    KEY_n = 1'b0; tick(3);
    KEY_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("bounce_level", int'(key_level), 0);
    end
    chk("bounce_count", int'(step_count), exp_cnt);

    // Auto-repeat; the release reaches the FSM exactly when the eighth repeat
    // interval expires, so that repeat must be suppressed.
    repeat_en = 1'b1;
    key_down(p);
    for (int k = 0; k < 7; k++) expect_ev(K_REP, p + RD + k * RR);
    exp_cnt = (exp_cnt + 7) % 16;
    tick(p + RD + 6 * RR - cyc);
    key_up();
    tick(DC + 6);
    chk("repeat_count", int'(step_count), exp_cnt);
    chk("repeat_release_level", int'(key_level), 0);
    repeat_en = 1'b0;

    // Wrap: 16 clean presses from zero.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_cnt = 0;
    chk("count_cleared", int'(step_count), 0);
    for (int i = 0; i < 16; i++) begin
      key_down(p);
      tick(DC + 4);
      key_up();
      tick(DC + 4);
      if (i == 14) chk("count_15", int'(step_count), 15);
    end
    chk("count_wrap", int'(step_count), 0);

    // Release bounce: a 2-cycle high glitch while held.
    key_down(p);
    tick(DC + 6);
    KEY_n = 1'b1; tick(2);
    KEY_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_level", int'(key_level), 1);
    end
    key_up();
    tick(DC + 4);
    chk("glitch_release_level", int'(key_level), 0);

    // Reset while in PRESS_WAIT (step_count is 1 here).
    KEY_n = 1'b0;
    tick(4);
    #2 reset = 1'b1;
    #1 chk_zero("rst_press_wait");
    tick(1);
    reset = 1'b0;
    exp_cnt = 0;
    key_down(p);

    // Then repeat until in REPEAT and reset again.
    repeat_en = 1'b1;
    expect_ev(K_REP, p + RD);
    exp_cnt = (exp_cnt + 1) % 16;
    tick(p + RD + 1 - cyc);
    #2 reset = 1'b1;
    #1 chk_zero("rst_repeat");
    tick(1);
    reset = 1'b0;
    exp_cnt = 0;
    key_down(p);
    repeat_en = 1'b0;
    tick(DC + 6);
    chk("post_reset_level", int'(key_level), 1);
    key_up();
    tick(DC + 4);
    chk("post_reset_count", int'(step_count), exp_cnt);

    tick(2);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
